// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter, active-low one-hot grants.
// A contended holder is forced off after MAX_HOLD cycles.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [0:3] grant_n,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int unsigned CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;

  logic [1:0] idx_nx;
  logic [1:0] win_idle;
  logic [1:0] win_rel;
  logic [3:0] others;
  logic       rel;

  // First requester at or after base, wrapping mod 4.
  function automatic logic [1:0] scan(
    input logic [1:0] base,
    input logic [3:0] r
  );
    logic [1:0] w;
    logic [1:0] j;
    w = base;
    for (int k = 3; k >= 0; k--) begin
      j = base + 2'(k);
      if (r[j]) w = j;
    end
    return w;
  endfunction

  function automatic logic [0:3] dec(input logic [1:0] i);
    logic [0:3] g;
    g = '1;
    g[i] = 1'b0;
    return g;
  endfunction

  assign idx_nx   = idx + 2'd1;
  assign win_idle = scan(ptr, req);
  assign win_rel  = scan(idx_nx, req);
  assign others   = req & ~(4'b0001 << idx);
  assign rel      = !req[idx] || ((cnt == CMAX) && (|others));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      grant_n   <= '1;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            idx       <= win_idle;
            cnt       <= '0;
            grant_n   <= dec(win_idle);
            gnt_idx   <= win_idle;
            gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= idx_nx;
            if (|req) begin
              idx       <= win_rel;
              cnt       <= '0;
              grant_n   <= dec(win_rel);
              gnt_idx   <= win_rel;
              gnt_valid <= 1'b1;
            end else begin
              state     <= IDLE;
              grant_n   <= '1;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end else if (cnt != CMAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: two instances (MAX_HOLD 8 and 1)
// against a holder/hold-time model plus literal expectations.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b1111;

  logic [0:3] gn [2];
  logic [1:0] gi [2];
  logic       gv [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_n(gn[0]), .gnt_idx(gi[0]), .gnt_valid(gv[0])
  );

  rr_arbiter_4 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant_n(gn[1]), .gnt_idx(gi[1]), .gnt_valid(gv[1])
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, got, exp);
    end
  endtask

  // Model: holder h (-1 = nobody), hold = cycles held so far.
  int mh [2] = '{8, 1};
  int h [2];
  int hold [2];
  int ptr [2];

  function automatic int scan(input int base, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  function automatic logic [0:3] exp_g(input int hh);
    logic [0:3] g;
    g = '1;
    if (hh >= 0) g[hh] = 1'b0;
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        h[m] <= -1;
        hold[m] <= 0;
        ptr[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int ch, cho, cp;
        bit contend, drop;
        ch = h[m]; cho = hold[m]; cp = ptr[m];
        if (ch < 0) begin
          if (req != 0) begin
            ch = scan(cp, req);
            cho = 1;
          end
        end else begin
          contend = (req & ~(4'b0001 << ch)) != 0;
          drop = !req[ch] || (cho >= mh[m] && contend);
          if (drop) begin
            cp = (ch + 1) % 4;
            if (req != 0) begin
              ch = scan(cp, req);
              cho = 1;
            end else begin
              ch = -1;
            end
          end else if (cho < 1000) begin
            cho = cho + 1;
          end
        end
        h[m] <= ch;
        hold[m] <= cho;
        ptr[m] <= cp;
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int zeros, zi;
      chk($sformatf("grant_n[%0d]", m), int'(gn[m]), int'(exp_g(h[m])));
      chk($sformatf("gnt_idx[%0d]", m), int'(gi[m]),
          (h[m] < 0) ? 0 : h[m]);
      chk($sformatf("gnt_valid[%0d]", m), int'(gv[m]), int'(h[m] >= 0));
      zeros = 0; zi = 0;
      for (int i = 0; i < 4; i++)
        if (!gn[m][i]) begin zeros++; zi = i; end
      chk($sformatf("onehot[%0d]", m), int'(zeros <= 1), 1);
      chk($sformatf("valid_inv[%0d]", m), int'(gv[m]), int'(!(&gn[m])));
      chk($sformatf("idx_inv[%0d]", m), int'(gi[m]), zi);
    end
  end

  task automatic pin(input int m, input logic [0:3] g, input int idx);
    chk($sformatf("pin_grant_n[%0d]", m), int'(gn[m]), int'(g));
    chk($sformatf("pin_idx[%0d]", m), int'(gi[m]), idx);
    chk($sformatf("pin_valid[%0d]", m), int'(gv[m]), int'(g != 4'b1111));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    pin(0, 4'b1111, 0);
    pin(1, 4'b1111, 0);
    @(negedge clk) rst_n = 1'b1;

    // Full contention from reset.
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin pin(0, 4'b0111, 0); pin(1, 4'b0111, 0); end
      if (c == 8) pin(0, 4'b0111, 0);
      if (c == 9) pin(0, 4'b1011, 1);
      if (c == 17) pin(0, 4'b1101, 2);
      if (c == 2) pin(1, 4'b1011, 1);
      if (c == 3) pin(1, 4'b1101, 2);
    end

    // Single request.
    req = 4'b0000;
    @(negedge clk);
    pin(0, 4'b1111, 0);
    req = 4'b0100;
    @(negedge clk);
    pin(0, 4'b1101, 2);
    pin(1, 4'b1101, 2);
    req = 4'b0000;
    @(negedge clk);
    pin(0, 4'b1111, 0);

    // Early release and handover 1 -> 3.
    req = 4'b0010;
    @(negedge clk);
    pin(0, 4'b1011, 1);
    req = 4'b1010;
    repeat (2) @(negedge clk);
    pin(0, 4'b1011, 1);
    req = 4'b1000;
    @(negedge clk);
    pin(0, 4'b1110, 3);

    // Uncontended hold.
    req = 4'b0000;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pin(0, 4'b0111, 0);
      pin(1, 4'b0111, 0);
    end

    // Reset in the middle of requester 2's grant.
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    pin(0, 4'b1101, 2);
    #2 rst_n = 1'b0;
    #1;
    pin(0, 4'b1111, 0);
    pin(1, 4'b1111, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    pin(0, 4'b0111, 0);
    pin(1, 4'b0111, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
